out_fifo_rd_ctrl: RTL and testbench
===================================

OUT_FIFO_RD_CTRL -- requirements
Module: out_fifo_rd_ctrl

Interface
REQ-001 The block SHALL have parameter CNT_WIDTH, default 16, setting the width of the delivered-word counter.
REQ-002 The block SHALL have parameter STALL_ON_ALMOSTEMPTY, default "FALSE": when "TRUE", new reads in RUN are issued only while FIFO_ALMOSTEMPTY=0.
REQ-003 The block SHALL have port RDCLK  input  1  read-side clock; all logic is on its rising edge.
REQ-004 The block SHALL have port RESET  input  1  asynchronous, active-high reset.
REQ-005 The block SHALL have port EN  input  1  drain enable.
REQ-006 The block SHALL have port CLR_STATUS  input  1  synchronous clear of WORD_CNT.
REQ-007 The block SHALL have port FIFO_EMPTY  input  1  upstream FIFO empty flag.
REQ-008 The block SHALL have port FIFO_ALMOSTEMPTY  input  1  upstream FIFO almost-empty flag.
REQ-009 The block SHALL have port FIFO_Q  input  40  upstream read data, lanes Q9..Q0 as nibbles, with Q0 on [3:0].
REQ-010 The block SHALL have port FIFO_RDEN  output  1  upstream read enable, combinational.
REQ-011 The block SHALL have port DOUT  output  40  delivered word, registered.
REQ-012 The block SHALL have port DVALID  output  1  DOUT valid.
REQ-013 The block SHALL have port DREADY  input  1  downstream accept.
REQ-014 The block SHALL have port WORD_CNT  output  CNT_WIDTH  count of accepted words.
REQ-015 The block SHALL have port BUSY  output  1  high whenever the state is not IDLE.

Function
REQ-016 Upstream read latency SHALL be one cycle: a word read with FIFO_RDEN=1 at edge N is captured from FIFO_Q at edge N+1.
REQ-017 The block SHALL hold a 2-entry FIFO-ordered skid buffer; occ (0..2) is the count of buffered words and infl (0..1) the count of in-flight reads.
REQ-018 The pop condition SHALL be pop = DVALID & DREADY; DVALID SHALL equal (occ>0), and DOUT SHALL be the head entry.
REQ-019 FIFO_RDEN SHALL equal state==RUN & ~FIFO_EMPTY & gate & (occ+infl-pop <= 1), where gate = ~FIFO_ALMOSTEMPTY if STALL_ON_ALMOSTEMPTY="TRUE", else 1.
REQ-020 The buffer SHALL never overflow: a captured word always finds a free entry, including a capture and a pop in the same cycle.
REQ-021 Word order SHALL be preserved exactly; no word SHALL be dropped or duplicated while DREADY toggles arbitrarily.
REQ-022 With DREADY held high and the FIFO non-empty, throughput SHALL be one word per cycle after a first-word latency of 2 cycles from FIFO_RDEN.
REQ-023 DOUT and DVALID SHALL remain stable while DVALID=1 & DREADY=0.
REQ-024 The state machine SHALL have states IDLE, RUN and FLUSH.
REQ-025 Transition IDLE->RUN SHALL occur when EN=1.
REQ-026 Transition RUN->FLUSH SHALL occur when EN=0.
REQ-027 In FLUSH, no reads SHALL be issued; the in-flight word is still captured, and the buffer is presented until occ=0 & infl=0, then the state SHALL go to IDLE.
REQ-028 Transition FLUSH->RUN SHALL occur if EN returns to 1 before the flush completes.
REQ-029 WORD_CNT SHALL increment on each pop and saturate at 2^CNT_WIDTH-1.
REQ-030 CLR_STATUS SHALL set WORD_CNT to 0 and take priority over a simultaneous pop.
REQ-031 FIFO_EMPTY rising while a read is in flight SHALL NOT cancel capture of that word.

Reset
REQ-032 While RESET=1, the block SHALL asynchronously force state IDLE, occ=0, infl=0, DVALID=0, DOUT=0, WORD_CNT=0, BUSY=0, and FIFO_RDEN=0.
REQ-033 A reset asserted mid-stream SHALL discard buffered and in-flight words; the first word delivered after reset SHALL be the first word read after reset.
REQ-034 After RESET deasserts, the block SHALL be in IDLE and SHALL start reading no earlier than the first edge at which EN=1 is sampled.

Verification
REQ-035 Streaming: EN=1, DREADY=1, FIFO holds 8 words 0x00..07 (replicated per nibble) -> 8 consecutive DVALID cycles in order, no gaps; WORD_CNT=8.
REQ-036 Backpressure: DREADY=0 for 5 cycles mid-stream -> FIFO_RDEN deasserts after occ+infl=2; DOUT is held; no loss; order is intact after DREADY=1.
REQ-037 Flush: EN drops with occ=1 and infl=1 -> exactly 2 more words are delivered, then BUSY=0, with no FIFO_RDEN during FLUSH.
REQ-038 Almost-empty stall: STALL_ON_ALMOSTEMPTY="TRUE", FIFO_ALMOSTEMPTY=1, FIFO_EMPTY=0 -> FIFO_RDEN stays 0; reads resume the cycle FIFO_ALMOSTEMPTY=0.
REQ-039 Counter: CNT_WIDTH=4 with 20 pops -> WORD_CNT saturates at 15; CLR_STATUS coincident with a pop -> WORD_CNT=0.
REQ-040 Reset mid-stream: RESET pulsed with occ=2 -> all outputs are 0 immediately; after release with EN=1, the first DOUT equals the next FIFO word.

Source files
------------

// File: rtl/out_fifo_rd_ctrl.sv
// out_fifo_rd_ctrl: drains an upstream one-cycle-latency FIFO into a 2-entry skid buffer with valid/ready output
module out_fifo_rd_ctrl #(
  parameter int    CNT_WIDTH            = 16,
  parameter string STALL_ON_ALMOSTEMPTY = "FALSE"
) (
  input  logic                 RDCLK,
  input  logic                 RESET,
  input  logic                 EN,
  input  logic                 CLR_STATUS,
  input  logic                 FIFO_EMPTY,
  input  logic                 FIFO_ALMOSTEMPTY,
  input  logic [39:0]          FIFO_Q,
  output logic                 FIFO_RDEN,
  output logic [39:0]          DOUT,
  output logic                 DVALID,
  input  logic                 DREADY,
  output logic [CNT_WIDTH-1:0] WORD_CNT,
  output logic                 BUSY
);
  localparam bit STALL = (STALL_ON_ALMOSTEMPTY == "TRUE");
  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;
  state_t               r_state, w_state_nxt;
  logic [39:0]          r_ent0, r_ent1;
  logic [1:0]           r_occ;
  logic                 r_infl;
  logic [CNT_WIDTH-1:0] r_word_cnt;
  logic                 w_pop, w_gate, w_room, w_slot0, w_slot1, w_drained;
  logic [1:0]           w_after_pop;
  assign DVALID   = r_occ != 2'd0;
  assign DOUT     = r_ent0;
  assign BUSY     = r_state != IDLE;
  assign WORD_CNT = r_word_cnt;
  // read issue: only request a word when it is guaranteed a free entry on arrival; next state
  always_comb begin
    w_pop       = DVALID & DREADY;
    w_gate      = STALL ? ~FIFO_ALMOSTEMPTY : 1'b1;
    w_after_pop = r_occ - {1'b0, w_pop};
    w_room      = (w_after_pop + {1'b0, r_infl}) <= 2'd1;
    FIFO_RDEN   = (r_state == RUN) & ~FIFO_EMPTY & w_gate & w_room;
    w_slot0     = r_infl & (w_after_pop == 2'd0);
    w_slot1     = r_infl & (w_after_pop == 2'd1);
    w_drained   = (r_occ == 2'd0) & ~r_infl;
    w_state_nxt = (r_state == IDLE) ? (EN ? RUN : IDLE) :
                  (r_state == RUN)  ? (EN ? RUN : FLUSH) :
                  (EN ? RUN : (w_drained ? IDLE : FLUSH));
  end
  // state register
  always_ff @(posedge RDCLK or posedge RESET) begin
    if (RESET) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end
  // skid buffer: entry 0 is the head; a capture lands in the first slot left free after this cycle's pop
  always_ff @(posedge RDCLK or posedge RESET) begin
    if (RESET) begin
      r_ent0 <= '0;
      r_ent1 <= '0;
      r_occ  <= '0;
      r_infl <= 1'b0;
    end else begin
      r_infl <= FIFO_RDEN;
      r_occ  <= w_after_pop + {1'b0, r_infl};
      r_ent0 <= w_slot0 ? FIFO_Q : (w_pop ? r_ent1 : r_ent0);
      r_ent1 <= w_slot1 ? FIFO_Q : r_ent1;
    end
  end
  // saturating count of accepted words; clear wins over a simultaneous pop
  always_ff @(posedge RDCLK or posedge RESET) begin
    if (RESET)                        r_word_cnt <= '0;
    else if (CLR_STATUS)              r_word_cnt <= '0;
    else if (w_pop & ~&r_word_cnt)    r_word_cnt <= r_word_cnt + 1'b1;
  end
endmodule

// File: tb/tb_out_fifo_rd_ctrl.sv
// tb_out_fifo_rd_ctrl: scoreboard bench with a queue-based upstream FIFO model and a decoupled monitor
module tb_out_fifo_rd_ctrl;
  logic        RDCLK = 1'b0, RESET = 1'b1, EN = 1'b0, CLR_STATUS = 1'b0;
  logic        FIFO_EMPTY = 1'b1, FIFO_ALMOSTEMPTY = 1'b0, DREADY = 1'b0;
  logic [39:0] FIFO_Q = '0;
  logic        FIFO_RDEN, DVALID, BUSY;
  logic [39:0] DOUT;
  logic [3:0]  WORD_CNT;
  int          checks = 0, failures = 0;
  logic [39:0] src[$];
  logic [39:0] exp_q[$];
  logic        rd_pend = 1'b0;
  int          out_m = 0, wc_m = 0;
  logic        held = 1'b0, mon_p;
  logic [39:0] held_d = '0;

  out_fifo_rd_ctrl #(.CNT_WIDTH(4), .STALL_ON_ALMOSTEMPTY("TRUE")) dut (
    .RDCLK(RDCLK), .RESET(RESET), .EN(EN), .CLR_STATUS(CLR_STATUS),
    .FIFO_EMPTY(FIFO_EMPTY), .FIFO_ALMOSTEMPTY(FIFO_ALMOSTEMPTY), .FIFO_Q(FIFO_Q),
    .FIFO_RDEN(FIFO_RDEN), .DOUT(DOUT), .DVALID(DVALID), .DREADY(DREADY),
    .WORD_CNT(WORD_CNT), .BUSY(BUSY)
  );

  always #5 RDCLK = ~RDCLK;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One cycle: upstream FIFO delivers the word read at the previous edge, then inputs are applied
  task automatic step(input logic en, input logic rdy, input logic ae, input logic clr);
    @(negedge RDCLK);
    if (rd_pend) begin
      if (src.size() == 0) begin
        checks++; failures++;
        $display("FAIL read_of_empty: got read expected none");
      end else begin
        FIFO_Q = src.pop_front();
        exp_q.push_back(FIFO_Q);
      end
    end
    FIFO_EMPTY = (src.size() == 0);
    EN = en; DREADY = rdy; FIFO_ALMOSTEMPTY = ae; CLR_STATUS = clr;
    #1 rd_pend = FIFO_RDEN;
  endtask

  // Monitor: order, hold-under-backpressure, occupancy bound and counter model
  always @(negedge RDCLK) begin
    #2;
    if (RESET) begin
      wc_m = 0; out_m = 0; held = 1'b0;
    end else begin
      chk("word_cnt", 64'(WORD_CNT), 64'(wc_m));
      if (held) begin
        chk("hold_valid", 64'(DVALID), 64'd1);
        chk("hold_dout", 64'(DOUT), 64'(held_d));
      end
      mon_p = DVALID & DREADY;
      if (mon_p) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL spurious_word: got %0h expected none", DOUT);
        end else chk("dout_order", 64'(DOUT), 64'(exp_q.pop_front()));
      end
      out_m = out_m + int'(FIFO_RDEN) - int'(mon_p);
      chk("occupancy_le2", 64'(out_m <= 2), 64'd1);
      wc_m = CLR_STATUS ? 0 : ((mon_p && wc_m < 15) ? wc_m + 1 : wc_m);
      held = DVALID & ~DREADY;
      held_d = DOUT;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int fr, fv, lv, nv, pops, rds, t;
    logic gap, done, found;
    logic [3:0] n;
    logic [39:0] d0, nxt;
    repeat (2) @(negedge RDCLK);
    #3 RESET = 1'b0;
    chk("rst_dvalid", 64'(DVALID), 64'd0);
    chk("rst_dout", 64'(DOUT), 64'd0);
    chk("rst_wcnt", 64'(WORD_CNT), 64'd0);
    chk("rst_busy", 64'(BUSY), 64'd0);
    chk("rst_rden", 64'(FIFO_RDEN), 64'd0);

    for (int i = 0; i < 8; i++) begin n = 4'(i); src.push_back({10{n}}); end
    fr = -1; fv = -1; lv = -1; nv = 0; gap = 1'b0;
    for (int c = 0; c < 16; c++) begin
      step(1, 1, 0, 0);
      if (FIFO_RDEN && fr < 0) fr = c;
      if (DVALID) begin
        if (fv < 0) fv = c; else if (lv != c - 1) gap = 1'b1;
        lv = c;
        n = 4'(nv);
        chk("stream_word", 64'(DOUT), 64'({10{n}}));
        nv++;
      end
    end
    chk("stream_count", 64'(nv), 64'd8);
    chk("stream_gap", 64'(gap), 64'd0);
    chk("stream_latency", 64'(fv - fr), 64'd2);
    chk("stream_wcnt", 64'(WORD_CNT), 64'd8);

    repeat (6) src.push_back(40'({$urandom(), $urandom()}));
    repeat (4) begin step(1, 1, 1, 0); chk("ae_stall_rden", 64'(FIFO_RDEN), 64'd0); end
    step(1, 1, 0, 0);
    chk("ae_resume_rden", 64'(FIFO_RDEN), 64'd1);

    repeat (50) src.push_back(40'({$urandom(), $urandom()}));
    repeat (5) step(1, 1, 0, 0);
    step(1, 0, 0, 0);
    d0 = DOUT;
    chk("bp_valid", 64'(DVALID), 64'd1);
    chk("bp_outstanding", 64'(out_m), 64'd2);
    chk("bp_rden", 64'(FIFO_RDEN), 64'd0);
    repeat (4) begin
      step(1, 0, 0, 0);
      chk("bp_rden", 64'(FIFO_RDEN), 64'd0);
      chk("bp_hold", 64'(DOUT), 64'(d0));
    end
    repeat (3) step(1, 1, 0, 0);

    repeat (20) step(1, 1, 0, 0);
    chk("cnt_saturate", 64'(WORD_CNT), 64'd15);
    step(1, 1, 0, 1);
    chk("clr_with_pop", 64'(DVALID), 64'd1);
    step(1, 1, 0, 0);
    chk("clr_cnt", 64'(WORD_CNT), 64'd0);

    repeat (3) step(1, 1, 0, 0);
    chk("flush_pre_outstanding", 64'(out_m), 64'd2);
    step(0, 0, 0, 0);
    chk("flush_drop_rden", 64'(FIFO_RDEN), 64'd0);
    pops = 0; rds = 0; done = 1'b0;
    for (int c = 0; c < 12 && !done; c++) begin
      step(0, 1, 0, 0);
      if (!BUSY) done = 1'b1;
      else begin pops += int'(DVALID); rds += int'(FIFO_RDEN); end
    end
    chk("flush_done", 64'(done), 64'd1);
    chk("flush_pops", 64'(pops), 64'd2);
    chk("flush_rden_count", 64'(rds), 64'd0);

    repeat (3) begin
      step(0, 1, 0, 0);
      chk("idle_rden", 64'(FIFO_RDEN), 64'd0);
      chk("idle_busy", 64'(BUSY), 64'd0);
    end
    step(1, 1, 0, 0);
    chk("en_sample_rden", 64'(FIFO_RDEN), 64'd0);
    step(1, 1, 0, 0);
    chk("start_after_en", 64'(FIFO_RDEN), 64'd1);

    repeat (10) src.push_back(40'({$urandom(), $urandom()}));
    repeat (6) step(1, 0, 0, 0);
    chk("rst_pre_outstanding", 64'(out_m), 64'd2);
    chk("rst_pre_valid", 64'(DVALID), 64'd1);
    #2 RESET = 1'b1;
    #1;
    chk("rst_mid_dvalid", 64'(DVALID), 64'd0);
    chk("rst_mid_dout", 64'(DOUT), 64'd0);
    chk("rst_mid_wcnt", 64'(WORD_CNT), 64'd0);
    chk("rst_mid_busy", 64'(BUSY), 64'd0);
    chk("rst_mid_rden", 64'(FIFO_RDEN), 64'd0);
    rd_pend = 1'b0;
    exp_q.delete();
    @(negedge RDCLK);
    #3 RESET = 1'b0;
    nxt = src[0];
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      step(1, 1, 0, 0);
      if (DVALID) begin
        found = 1'b1;
        chk("rst_first_word", 64'(DOUT), 64'(nxt));
      end
    end
    chk("rst_first_found", 64'(found), 64'd1);

    for (int c = 0; c < 400; c++) begin
      if (src.size() < 4) src.push_back(40'({$urandom(), $urandom()}));
      step(logic'($urandom_range(0, 9) != 0), logic'($urandom_range(0, 1)),
           logic'($urandom_range(0, 4) == 0), logic'($urandom_range(0, 19) == 0));
    end

    t = 0;
    while ((src.size() != 0 || exp_q.size() != 0 || out_m != 0 || rd_pend) && t < 300) begin
      step(1, 1, 0, 0);
      t++;
    end
    chk("drain_complete", 64'(t < 300), 64'd1);
    repeat (2) step(0, 1, 0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
